// File: rtl/cpu_defs.sv
// Shared core definitions: register numbers, instruction field
// positions, condition/opcode constants and the LSU state encoding.
package cpu_defs;

  localparam logic [3:0] R14 = 4'd14;
  localparam logic [3:0] R15 = 4'd15;

  localparam int BIT_I = 25;
  localparam int BIT_P = 24;
  localparam int BIT_U = 23;
  localparam int BIT_B = 22;
  localparam int BIT_W = 21;
  localparam int BIT_L = 20;

  typedef enum logic [1:0] {
    IT_DP  = 2'b00,
    IT_MEM = 2'b01,
    IT_BR  = 2'b10,
    IT_SWI = 2'b11
  } inst_type_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_AL = 4'he;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_CMP = 4'ha;
  localparam logic [3:0] OP_MOV = 4'hd;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_t;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM; registered read that holds its
// output between read enables, write on enable.
module sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle load/store unit with private data memory:
// handshake, wait states, byte lanes, indexing and writeback.
module lsu_mem
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_WORDS  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_byte,
  input  logic                  req_pre,
  input  logic                  req_up,
  input  logic                  req_wb,
  input  logic [DATA_WIDTH-1:0] req_base,
  input  logic [11:0]           req_offset,
  input  logic [DATA_WIDTH-1:0] req_store_data,
  input  logic [3:0]            req_rd,
  input  logic [3:0]            req_rn,
  output logic                  resp_valid,
  output logic                  resp_ld_we,
  output logic [3:0]            resp_ld_reg,
  output logic [DATA_WIDTH-1:0] resp_ld_data,
  output logic                  resp_wb_we,
  output logic [3:0]            resp_wb_reg,
  output logic [DATA_WIDTH-1:0] resp_wb_data,
  output logic                  resp_fault
);

  localparam int AW = $clog2(DATA_WORDS);

  lsu_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;

  logic [DATA_WIDTH-1:0] off_in;
  logic [AW+1:0]         acc_in;
  logic                  fault_in;
  logic                  wb_in;

  logic                  load_q, byte_q, wbe_q;
  logic [AW-1:0]         idx_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] off_q, wdata_q;
  logic [3:0]            rd_q, rn_q;

  logic                  ram_re, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata, merge_w, ld_fresh, ld_hold_q;
  logic [7:0]            rd_byte;

  assign off_in = req_up ? req_base + DATA_WIDTH'(req_offset)
                         : req_base - DATA_WIDTH'(req_offset);
  assign acc_in = req_pre ? off_in[AW+1:0] : req_base[AW+1:0];
  assign fault_in = !req_byte && (acc_in[1:0] != 2'b00);
  assign wb_in = (!req_pre || req_wb) && (req_rn != R15)
               && !(req_load && (req_rn == req_rd));

  assign req_ready = (state_q == S_IDLE);

  // next-state logic and request acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (fault_in)
            state_d = S_RESP;
          else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else
            state_d = (req_load || req_byte) ? S_READ : S_WRITE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = (load_q || byte_q) ? S_READ : S_WRITE;
        else
          cnt_d = cnt_q - 4'd1;
      end
      S_READ:  state_d = load_q ? S_RESP : S_MERGE;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // request capture; byte stores fold the merged word in MERGE
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      wbe_q   <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      off_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 4'd0;
      rn_q    <= 4'd0;
    end else if (accept) begin
      load_q  <= req_load;
      byte_q  <= req_byte;
      wbe_q   <= wb_in;
      idx_q   <= acc_in[AW+1:2];
      lane_q  <= acc_in[1:0];
      off_q   <= off_in;
      wdata_q <= req_store_data;
      rd_q    <= req_rd;
      rn_q    <= req_rn;
    end else if (state_q == S_MERGE) begin
      wdata_q <= merge_w;
    end
  end

  assign ram_re = (state_q == S_READ);
  assign ram_we = (state_q == S_WRITE) && !reset;

  sync_ram #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DATA_WORDS)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign rd_byte  = ram_rdata[{lane_q, 3'b000} +: 8];
  assign ld_fresh = byte_q ? DATA_WIDTH'(rd_byte) : ram_rdata;

  // insert the store byte into the word just read
  always_comb begin
    merge_w = ram_rdata;
    merge_w[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  // response control fields, loaded when entering RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_fault   <= 1'b0;
      resp_ld_we   <= 1'b0;
      resp_wb_we   <= 1'b0;
      resp_ld_reg  <= 4'd0;
      resp_wb_reg  <= 4'd0;
      resp_wb_data <= '0;
    end else begin
      resp_valid <= (state_d == S_RESP);
      if (state_d == S_RESP) begin
        if (state_q == S_IDLE) begin
          resp_fault   <= 1'b1;
          resp_ld_we   <= 1'b0;
          resp_wb_we   <= 1'b0;
          resp_ld_reg  <= req_rd;
          resp_wb_reg  <= req_rn;
          resp_wb_data <= off_in;
        end else begin
          resp_fault   <= 1'b0;
          resp_ld_we   <= load_q;
          resp_wb_we   <= wbe_q;
          resp_ld_reg  <= rd_q;
          resp_wb_reg  <= rn_q;
          resp_wb_data <= off_q;
        end
      end
    end
  end

  assign resp_ld_data = (state_q == S_RESP && resp_ld_we)
                      ? ld_fresh : ld_hold_q;

  // keep load data stable after the response pulse
  always_ff @(posedge clk) begin
    if (reset)
      ld_hold_q <= '0;
    else
      ld_hold_q <= resp_ld_data;
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: two instances (0 and 3 wait states) share
// stimulus and are checked every cycle against a reference model.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_byte, req_pre, req_up, req_wb;
  logic [31:0] req_base, req_store_data;
  logic [11:0] req_offset;
  logic [3:0]  req_rd, req_rn;

  always #5 clk = ~clk;

  logic        rdy0, val0, lwe0, wwe0, flt0;
  logic        rdy3, val3, lwe3, wwe3, flt3;
  logic [3:0]  lrg0, wrg0, lrg3, wrg3;
  logic [31:0] ldd0, wbd0, ldd3, wbd3;

  lsu_mem #(.DATA_WIDTH(32), .DATA_WORDS(32), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_load(req_load), .req_byte(req_byte), .req_pre(req_pre),
    .req_up(req_up), .req_wb(req_wb), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data),
    .req_rd(req_rd), .req_rn(req_rn), .resp_valid(val0),
    .resp_ld_we(lwe0), .resp_ld_reg(lrg0), .resp_ld_data(ldd0),
    .resp_wb_we(wwe0), .resp_wb_reg(wrg0), .resp_wb_data(wbd0),
    .resp_fault(flt0));

  lsu_mem #(.DATA_WIDTH(32), .DATA_WORDS(32), .WAIT_STATES(3)) u_d3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
    .req_load(req_load), .req_byte(req_byte), .req_pre(req_pre),
    .req_up(req_up), .req_wb(req_wb), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data),
    .req_rd(req_rd), .req_rn(req_rn), .resp_valid(val3),
    .resp_ld_we(lwe3), .resp_ld_reg(lrg3), .resp_ld_data(ldd3),
    .resp_wb_we(wwe3), .resp_wb_reg(wrg3), .resp_wb_data(wbd3),
    .resp_fault(flt3));

  logic [1:0]        o_ready, o_valid, o_ld_we, o_wb_we, o_fault;
  logic [1:0][3:0]   o_ld_reg, o_wb_reg;
  logic [1:0][31:0]  o_ld_data, o_wb_data;

  assign o_ready   = {rdy3, rdy0};
  assign o_valid   = {val3, val0};
  assign o_ld_we   = {lwe3, lwe0};
  assign o_wb_we   = {wwe3, wwe0};
  assign o_fault   = {flt3, flt0};
  assign o_ld_reg  = {lrg3, lrg0};
  assign o_wb_reg  = {wrg3, wrg0};
  assign o_ld_data = {ldd3, ldd0};
  assign o_wb_data = {wbd3, wbd0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  // reference model: memory image plus one expected transaction
  logic [31:0] mmem [2][32];
  bit          started = 0;
  bit          m_busy [2], m_resp [2], m_zero [2];
  int          m_rem  [2];
  bit          p_store [2];
  int          p_idx   [2];
  logic [31:0] p_word  [2];
  bit          e_valid [2], e_fault [2], e_ld_we [2], e_wb_we [2];
  logic [3:0]  e_ld_reg [2], e_wb_reg [2];
  logic [31:0] e_ld_data [2], e_wb_data [2];

  task automatic model_done(input int i);
    if (p_store[i])
      mmem[i][p_idx[i]] = p_word[i];
    m_resp[i]  = 1;
    e_valid[i] = 1;
    m_zero[i]  = 0;
  endtask

  task automatic model_accept(input int i);
    logic [31:0] off, acc, word, sb;
    int lane, idx, ws, lat;
    bit fault, wbreq;
    off   = req_up ? req_base + {20'd0, req_offset}
                   : req_base - {20'd0, req_offset};
    acc   = req_pre ? off : req_base;
    idx   = int'((acc / 4) % 32);
    lane  = int'(acc % 4);
    fault = !req_byte && lane != 0;
    wbreq = (!req_pre || req_wb) && req_rn != 4'd15
          && !(req_load && req_rn == req_rd);
    word  = mmem[i][idx];
    e_fault[i]   = fault;
    e_ld_we[i]   = req_load && !fault;
    e_wb_we[i]   = wbreq && !fault;
    e_ld_reg[i]  = req_rd;
    e_wb_reg[i]  = req_rn;
    e_wb_data[i] = off;
    e_ld_data[i] = req_byte ? ((word >> (8 * lane)) & 32'hff) : word;
    sb = {24'd0, req_store_data[7:0]};
    p_store[i] = !req_load && !fault;
    p_idx[i]   = idx;
    p_word[i]  = req_byte
               ? ((word & ~(32'hff << (8 * lane))) | (sb << (8 * lane)))
               : req_store_data;
    ws  = (i == 0) ? 0 : 3;
    lat = fault ? 1 : (!req_load && req_byte) ? 4 + ws : 2 + ws;
    m_rem[i] = lat - 1;
    if (m_rem[i] == 0)
      model_done(i);
    else
      m_busy[i] = 1;
  endtask

  always @(posedge clk) begin
    if (reset)
      started = 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i]  = 0;
        m_resp[i]  = 0;
        e_valid[i] = 0;
        m_zero[i]  = 1;
      end else if (m_resp[i]) begin
        m_resp[i]  = 0;
        e_valid[i] = 0;
      end else if (m_busy[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_busy[i] = 0;
          model_done(i);
        end
      end else if (req_valid) begin
        model_accept(i);
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready", i, 32'(o_ready[i]), 32'(!(m_busy[i] || m_resp[i])));
        chk("resp_valid", i, 32'(o_valid[i]), 32'(e_valid[i]));
        if (e_valid[i]) begin
          chk("fault", i, 32'(o_fault[i]), 32'(e_fault[i]));
          chk("ld_we", i, 32'(o_ld_we[i]), 32'(e_ld_we[i]));
          chk("wb_we", i, 32'(o_wb_we[i]), 32'(e_wb_we[i]));
          if (e_ld_we[i]) begin
            chk("ld_reg", i, 32'(o_ld_reg[i]), 32'(e_ld_reg[i]));
            chk("ld_data", i, o_ld_data[i], e_ld_data[i]);
          end
          if (e_wb_we[i]) begin
            chk("wb_reg", i, 32'(o_wb_reg[i]), 32'(e_wb_reg[i]));
            chk("wb_data", i, o_wb_data[i], e_wb_data[i]);
          end
        end
        if (m_zero[i]) begin
          chk("rst_ld_we", i, 32'(o_ld_we[i]), 32'd0);
          chk("rst_wb_we", i, 32'(o_wb_we[i]), 32'd0);
          chk("rst_fault", i, 32'(o_fault[i]), 32'd0);
          chk("rst_ld_reg", i, 32'(o_ld_reg[i]), 32'd0);
          chk("rst_wb_reg", i, 32'(o_wb_reg[i]), 32'd0);
          chk("rst_ld_data", i, o_ld_data[i], 32'd0);
          chk("rst_wb_data", i, o_wb_data[i], 32'd0);
        end
      end
    end
  end

  int          lat [2];
  logic [31:0] c_ld_data [2], c_wb_data [2];
  logic        c_ld_we [2], c_wb_we [2], c_fault [2];

  task automatic drive(input bit ld, by, pre, up, wb,
                       input logic [31:0] base, input logic [11:0] off,
                       input logic [31:0] data,
                       input logic [3:0] rd, input logic [3:0] rn);
    req_load = ld; req_byte = by; req_pre = pre; req_up = up;
    req_wb = wb; req_base = base; req_offset = off;
    req_store_data = data; req_rd = rd; req_rn = rn;
    req_valid = 1'b1;
  endtask

  // one request to both units; records latency and response fields
  task automatic run_req(input bit ld, by, pre, up, wb,
                         input logic [31:0] base, input logic [11:0] off,
                         input logic [31:0] data,
                         input logic [3:0] rd, input logic [3:0] rn);
    int k;
    drive(ld, by, pre, up, wb, base, off, data, rd, rn);
    lat[0] = -1;
    lat[1] = -1;
    k = 0;
    while (k < 40 && (lat[0] < 0 || lat[1] < 0)) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (o_valid[i] && lat[i] < 0) begin
          lat[i]       = k;
          c_ld_data[i] = o_ld_data[i];
          c_wb_data[i] = o_wb_data[i];
          c_ld_we[i]   = o_ld_we[i];
          c_wb_we[i]   = o_wb_we[i];
          c_fault[i]   = o_fault[i];
        end
      end
    end
    if (lat[0] < 0 || lat[1] < 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: lat0 %0d lat3 %0d required a pulse",
               lat[0], lat[1]);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++)
        mmem[i][j] = 32'd0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, first_ready;
    reset = 1'b1;
    req_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0, 12'd0, 32'd0, 4'd0, 4'd0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_req(0, 0, 1, 1, 0, 32'h10, 12'd4, 32'hdeadbeef, 4'd1, 4'd3);
    chk("str_lat", 0, lat[0], 2);
    chk("str_lat", 1, lat[1], 5);
    chk("str_wb_we", 0, 32'(c_wb_we[0]), 0);

    run_req(1, 0, 1, 1, 0, 32'h10, 12'd4, 32'd0, 4'd4, 4'd3);
    chk("ldr_data", 0, c_ld_data[0], 32'hdeadbeef);
    chk("ldr_data", 1, c_ld_data[1], 32'hdeadbeef);
    chk("ldr_we", 0, 32'(c_ld_we[0]), 1);
    chk("ldr_lat", 1, lat[1], 5);

    run_req(0, 0, 1, 1, 0, 32'h14, 12'd0, 32'h11223344, 4'd1, 4'd3);
    run_req(0, 1, 1, 1, 0, 32'h15, 12'd0, 32'h000000aa, 4'd1, 4'd3);
    chk("strb_lat", 0, lat[0], 4);
    chk("strb_lat", 1, lat[1], 7);
    run_req(1, 0, 1, 1, 0, 32'h14, 12'd0, 32'd0, 4'd4, 4'd3);
    chk("strb_merge", 0, c_ld_data[0], 32'h1122aa44);

    run_req(1, 1, 1, 1, 0, 32'h14, 12'd2, 32'd0, 4'd4, 4'd3);
    chk("ldrb_data", 0, c_ld_data[0], 32'h00000022);
    chk("ldrb_lat", 0, lat[0], 2);

    run_req(0, 0, 1, 1, 0, 32'h20, 12'd0, 32'hcafef00d, 4'd1, 4'd3);
    run_req(1, 0, 0, 0, 0, 32'h20, 12'd8, 32'd0, 4'd5, 4'd2);
    chk("post_data", 0, c_ld_data[0], 32'hcafef00d);
    chk("post_wb_we", 0, 32'(c_wb_we[0]), 1);
    chk("post_wb_data", 0, c_wb_data[0], 32'h18);

    run_req(1, 0, 1, 1, 1, 32'h20, 12'd2, 32'd0, 4'd6, 4'd7);
    chk("mis_fault", 0, 32'(c_fault[0]), 1);
    chk("mis_lat", 0, lat[0], 1);
    chk("mis_lat", 1, lat[1], 1);
    chk("mis_ld_we", 0, 32'(c_ld_we[0]), 0);
    chk("mis_wb_we", 0, 32'(c_wb_we[0]), 0);
    run_req(1, 0, 1, 1, 0, 32'h20, 12'd0, 32'd0, 4'd6, 4'd7);
    chk("mis_unchanged", 0, c_ld_data[0], 32'hcafef00d);

    run_req(1, 0, 0, 1, 0, 32'h20, 12'd4, 32'd0, 4'd2, 4'd2);
    chk("rn_eq_rd_wb", 0, 32'(c_wb_we[0]), 0);
    chk("rn_eq_rd_ld", 0, 32'(c_ld_we[0]), 1);

    run_req(0, 0, 1, 1, 1, 32'h80, 12'd0, 32'h0badcafe, 4'd1, 4'd15);
    chk("r15_wb_we", 0, 32'(c_wb_we[0]), 0);
    run_req(1, 0, 1, 1, 0, 32'h0, 12'd0, 32'd0, 4'd3, 4'd4);
    chk("wrap_data", 0, c_ld_data[0], 32'h0badcafe);

    run_req(0, 0, 1, 0, 1, 32'h30, 12'h10, 32'h00000077, 4'd1, 4'd4);
    chk("sub_wb_data", 0, c_wb_data[0], 32'h20);
    chk("sub_wb_we", 0, 32'(c_wb_we[0]), 1);

    // held request: the 3-wait unit must not re-accept before RESP ends
    drive(1, 0, 1, 1, 0, 32'h14, 12'd0, 32'd0, 4'd8, 4'd9);
    first_ready = -1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (first_ready < 0 && o_ready[1])
        first_ready = k;
      if (first_ready > 0 && k == first_ready + 1)
        req_valid = 1'b0;
      if (!req_valid && o_ready == 2'b11)
        break;
    end
    chk("held_ready_at", 1, first_ready, 6);
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL held_timeout: units busy after %0d cycles", k);
    end

    // reset during the wait of a store aborts the write
    run_req(0, 0, 1, 1, 0, 32'h08, 12'd0, 32'h12345678, 4'd1, 4'd3);
    drive(0, 0, 1, 1, 0, 32'h08, 12'd0, 32'h00000055, 4'd1, 4'd3);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_idle", 0, 32'(o_ready[0]), 1);
    chk("rst_idle", 1, 32'(o_ready[1]), 1);
    run_req(1, 0, 1, 1, 0, 32'h08, 12'd0, 32'd0, 4'd5, 4'd3);
    chk("rst_no_write", 0, c_ld_data[0], 32'h12345678);
    chk("rst_no_write", 1, c_ld_data[1], 32'h12345678);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
